aes_inv_state_manager: RTL and testbench
========================================

Name: aes_inv_state_manager

Overview:
Control FSM for the AES-128 inverse cipher. It loads ciphertext columns and then key columns, waits for round-key expansion, and sequences AddRoundKey(10) followed by rounds 9..0 (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns; InvMixColumns is omitted in round 0), then gates plaintext readout. It drives the same state-matrix mux/index/write-enable interface as the encryption controller, plus a round-key index for the key store.

Parameters:
NR, 10, number of rounds; fixed for AES-128; sets the round-counter load value.
KEY_TIMEOUT_CYCLES, 256, COMPUTE_ROUNDKEYS watchdog limit; used only with AES_INV_KEY_TIMEOUT_EN.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start_write_n  in  1  active-low request to load ciphertext, then key; sampled in IDLE only.
start_read_n  in  1  active-low request to read plaintext; sampled in DECRYPTION_DONE only.
key_expand_done  in  1  round keys ready; sampled in COMPUTE_ROUNDKEYS only.
done  out  1  plaintext available.
dbg_state  out  6  current state encoding.
dbg_round  out  4  current round_counter.
matrix_in_sel  out  4  matrix write source: 0 ctext, 4 AddRoundKey, 5 InvSubBytes, 6 InvShiftRows, 7 InvMixColumns.
matrix_write_enable  out  1  state-matrix write strobe.
input_mat_row_col  out  1  write slice type: 0 row, 1 column.
input_mat_idx  out  2  write slice index.
output_mat_row_col  out  1  read slice type: 0 row, 1 column.
output_mat_idx  out  2  read slice index.
key_start  out  1  one-cycle key-expansion start.
round_key_idx  out  4  round key selected for AddRoundKey (0..10).
count_4_out  out  2  slice counter, for monitoring.

Behaviour:
- Registers: state, round_counter[3:0], count_4[1:0]. All outputs are combinational from these registers.
- Reset (asynchronous): state=IDLE, round_counter=0, count_4=0. Resulting outputs are all 0: done=0, write enable=0, key_start=0, sel=0, indices=0, dbg_state=0, dbg_round=0, round_key_idx=0.
- State encodings: IDLE=0, CTEXT_WRITE=1, KEY_WRITE=2, COMPUTE_ROUNDKEYS=3, INIT_ADDROUNDKEY=4, INV_SHIFTROWS=5, INV_SUBBYTES=6, ADDROUNDKEY=7, INV_MIXCOLUMNS=8, DECRYPTION_DONE=9, PTEXT_READ=10. Any other encoding goes to IDLE with both counters cleared.
- Every working state (1, 2, 4–8, 10) lasts exactly 4 cycles, with count_4 stepping 0..3 and cleared on exit.
- IDLE: start_write_n=0 -> CTEXT_WRITE. If start_write_n and start_read_n are both low, write wins.
- CTEXT_WRITE: sel=0, we=1, in_rc=1, in_idx=count_4. Exit -> KEY_WRITE.
- KEY_WRITE: we=0, in_rc=1, in_idx=count_4, key_start=1 only when count_4=0. Exit -> COMPUTE_ROUNDKEYS.
- COMPUTE_ROUNDKEYS: waits indefinitely. key_expand_done=1 -> INIT_ADDROUNDKEY, round_counter<=NR.
- INIT_ADDROUNDKEY: sel=4, we=1, in and out on columns, idx=count_4. Exit -> INV_SHIFTROWS, round_counter<=NR-1.
- INV_SHIFTROWS: sel=6, rows. Exit -> INV_SUBBYTES.
- INV_SUBBYTES: sel=5, rows. Exit -> ADDROUNDKEY.
- ADDROUNDKEY: sel=4, columns. Exit: round_counter=0 -> DECRYPTION_DONE; otherwise -> INV_MIXCOLUMNS.
- INV_MIXCOLUMNS: sel=7, columns. Exit -> INV_SHIFTROWS, round_counter<=round_counter-1.
- round_key_idx = round_counter in INIT_ADDROUNDKEY and ADDROUNDKEY; 0 in all other states.
- DECRYPTION_DONE: done=1 (level). start_read_n=0 -> PTEXT_READ.
- PTEXT_READ: we=0, out_rc=1, out_idx=count_4, done=0. Exit -> IDLE.
- Non-working states drive sel=0, we=0, and indices 0.
- Latency: 160 cycles from the first COMPUTE_ROUNDKEYS exit edge to DECRYPTION_DONE (4 + 9×16 + 12).
- Ignored inputs: start_write_n outside IDLE, start_read_n outside DECRYPTION_DONE, and key_expand_done outside COMPUTE_ROUNDKEYS are all ignored.
- round_counter never wraps below 0.
- Reset asserted mid-operation returns the block to IDLE immediately; no partial output persists.

Optional Feature:
AES_INV_KEY_TIMEOUT_EN
- Defined: adds output key_timeout (1 bit) and a cycle counter of width $clog2(KEY_TIMEOUT_CYCLES)+1, cleared on entry to COMPUTE_ROUNDKEYS. If KEY_TIMEOUT_CYCLES cycles elapse without key_expand_done, the FSM goes to IDLE and key_timeout pulses high for 1 cycle. key_expand_done arriving on the final cycle wins over the timeout.
- Undefined: the port and the counter do not exist; COMPUTE_ROUNDKEYS waits indefinitely.

Test Plan:
- Reset, then start_write_n low for 1 cycle -> 4 cycles of CTEXT_WRITE with we=1 and in_idx 0,1,2,3, then KEY_WRITE with key_start high on its first cycle only.
- key_expand_done raised 5 cycles after entering COMPUTE_ROUNDKEYS -> INIT_ADDROUNDKEY with round_key_idx=10, then INV_SHIFTROWS with dbg_round=9; done rises exactly 160 cycles later.
- Full run -> sel sequence per round is 6,5,4,7 for rounds 9..1 and 6,5,4 for round 0; ADDROUNDKEY round_key_idx sequence is 10,9,…,0; state 8 never occurs at round 0.
- In DECRYPTION_DONE, start_read_n low -> done falls, out_rc=1, out_idx 0..3, then IDLE. start_write_n pulsed during the run -> no effect.
- reset_n low at cycle 50 of the rounds -> immediately IDLE with all outputs 0. A fresh start then completes normally.
- AES_INV_KEY_TIMEOUT_EN defined, KEY_TIMEOUT_CYCLES=16, key_expand_done never raised -> key_timeout pulses once after 16 cycles and state returns to 0.

Source files
------------

// File: rtl/aes_inv_state_manager_if.sv
// Handshake, debug and state-matrix control bundle for aes_inv_state_manager.
// key_timeout exists only when AES_INV_KEY_TIMEOUT_EN is defined.
interface aes_inv_state_manager_if;
    logic       start_write_n;
    logic       start_read_n;
    logic       key_expand_done;
    logic       done;
    logic [5:0] dbg_state;
    logic [3:0] dbg_round;
    logic [3:0] matrix_in_sel;
    logic       matrix_write_enable;
    logic       input_mat_row_col;
    logic [1:0] input_mat_idx;
    logic       output_mat_row_col;
    logic [1:0] output_mat_idx;
    logic       key_start;
    logic [3:0] round_key_idx;
    logic [1:0] count_4_out;
`ifdef AES_INV_KEY_TIMEOUT_EN
    logic       key_timeout;
`endif

    modport master (
`ifdef AES_INV_KEY_TIMEOUT_EN
        input  key_timeout,
`endif
        output start_write_n,
        output start_read_n,
        output key_expand_done,
        input  done,
        input  dbg_state,
        input  dbg_round,
        input  matrix_in_sel,
        input  matrix_write_enable,
        input  input_mat_row_col,
        input  input_mat_idx,
        input  output_mat_row_col,
        input  output_mat_idx,
        input  key_start,
        input  round_key_idx,
        input  count_4_out
    );

    modport slave (
`ifdef AES_INV_KEY_TIMEOUT_EN
        output key_timeout,
`endif
        input  start_write_n,
        input  start_read_n,
        input  key_expand_done,
        output done,
        output dbg_state,
        output dbg_round,
        output matrix_in_sel,
        output matrix_write_enable,
        output input_mat_row_col,
        output input_mat_idx,
        output output_mat_row_col,
        output output_mat_idx,
        output key_start,
        output round_key_idx,
        output count_4_out
    );
endinterface

// File: rtl/aes_inv_state_manager.sv
// AES-128 inverse-cipher control FSM: ciphertext/key load, key-expansion wait, rounds 10..0, readout.
// Define AES_INV_KEY_TIMEOUT_EN to add a COMPUTE_ROUNDKEYS watchdog and the key_timeout output.
module aes_inv_state_manager #(
    parameter int NR = 10,
    parameter int KEY_TIMEOUT_CYCLES = 256
) (
    input  logic                   clock,
    input  logic                   reset_n,
    aes_inv_state_manager_if.slave bus
);
    localparam logic [5:0] S_IDLE              = 6'd0;
    localparam logic [5:0] S_CTEXT_WRITE       = 6'd1;
    localparam logic [5:0] S_KEY_WRITE         = 6'd2;
    localparam logic [5:0] S_COMPUTE_ROUNDKEYS = 6'd3;
    localparam logic [5:0] S_INIT_ADDROUNDKEY  = 6'd4;
    localparam logic [5:0] S_INV_SHIFTROWS     = 6'd5;
    localparam logic [5:0] S_INV_SUBBYTES      = 6'd6;
    localparam logic [5:0] S_ADDROUNDKEY       = 6'd7;
    localparam logic [5:0] S_INV_MIXCOLUMNS    = 6'd8;
    localparam logic [5:0] S_DECRYPTION_DONE   = 6'd9;
    localparam logic [5:0] S_PTEXT_READ        = 6'd10;

    localparam logic [3:0] SEL_CTEXT = 4'd0;
    localparam logic [3:0] SEL_ARK   = 4'd4;
    localparam logic [3:0] SEL_ISB   = 4'd5;
    localparam logic [3:0] SEL_ISR   = 4'd6;
    localparam logic [3:0] SEL_IMC   = 4'd7;

    localparam logic [3:0] ROUND_FIRST = 4'(NR);
    localparam logic [3:0] ROUND_NEXT  = 4'(NR - 1);

    logic [5:0] state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [1:0] count_q, count_d;
    logic       last_slice;
    logic       working;

    assign last_slice = (count_q == 2'd3);

    // States that spend exactly four cycles walking count_4 across the matrix slices.
    always_comb begin
        working = 1'b0;
        case (state_q)
            S_CTEXT_WRITE, S_KEY_WRITE, S_INIT_ADDROUNDKEY, S_INV_SHIFTROWS,
            S_INV_SUBBYTES, S_ADDROUNDKEY, S_INV_MIXCOLUMNS, S_PTEXT_READ: working = 1'b1;
            default: working = 1'b0;
        endcase
    end

`ifdef AES_INV_KEY_TIMEOUT_EN
    localparam int TIMER_W = $clog2(KEY_TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(KEY_TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               key_timeout_q, key_timeout_d;
    logic               timer_expired;

    assign timer_expired = (timer_q == TIMER_LAST);

    // Held at zero outside COMPUTE_ROUNDKEYS, so every entry starts a fresh count.
    always_comb begin
        timer_d       = '0;
        key_timeout_d = 1'b0;
        if (state_q == S_COMPUTE_ROUNDKEYS) begin
            timer_d       = timer_q + 1'b1;
            key_timeout_d = timer_expired && !bus.key_expand_done;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_q       <= '0;
            key_timeout_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            key_timeout_q <= key_timeout_d;
        end
    end

    assign bus.key_timeout = key_timeout_q;
`endif

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        count_d = '0;
        if (working) begin
            count_d = last_slice ? 2'd0 : count_q + 2'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (!bus.start_write_n) state_d = S_CTEXT_WRITE;
            end
            S_CTEXT_WRITE: begin
                if (last_slice) state_d = S_KEY_WRITE;
            end
            S_KEY_WRITE: begin
                if (last_slice) state_d = S_COMPUTE_ROUNDKEYS;
            end
            S_COMPUTE_ROUNDKEYS: begin
                if (bus.key_expand_done) begin
                    state_d = S_INIT_ADDROUNDKEY;
                    round_d = ROUND_FIRST;
                end
`ifdef AES_INV_KEY_TIMEOUT_EN
                else if (timer_expired) begin
                    state_d = S_IDLE;
                end
`endif
            end
            S_INIT_ADDROUNDKEY: begin
                if (last_slice) begin
                    state_d = S_INV_SHIFTROWS;
                    round_d = ROUND_NEXT;
                end
            end
            S_INV_SHIFTROWS: begin
                if (last_slice) state_d = S_INV_SUBBYTES;
            end
            S_INV_SUBBYTES: begin
                if (last_slice) state_d = S_ADDROUNDKEY;
            end
            // Round 0 has no InvMixColumns: leave straight from AddRoundKey.
            S_ADDROUNDKEY: begin
                if (last_slice) begin
                    state_d = (round_q == 4'd0) ? S_DECRYPTION_DONE : S_INV_MIXCOLUMNS;
                end
            end
            S_INV_MIXCOLUMNS: begin
                if (last_slice) begin
                    state_d = S_INV_SHIFTROWS;
                    round_d = (round_q != 4'd0) ? round_q - 4'd1 : 4'd0;
                end
            end
            S_DECRYPTION_DONE: begin
                if (!bus.start_read_n) state_d = S_PTEXT_READ;
            end
            S_PTEXT_READ: begin
                if (last_slice) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            round_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            count_q <= count_d;
        end
    end

    logic [3:0] sel;
    logic       we;
    logic       in_rc;
    logic [1:0] in_idx;
    logic       out_rc;
    logic [1:0] out_idx;
    logic       key_start;
    logic [3:0] rk_idx;
    logic       done;

    // Output decode is purely a function of the registered state.
    always_comb begin
        sel       = SEL_CTEXT;
        we        = 1'b0;
        in_rc     = 1'b0;
        in_idx    = 2'd0;
        out_rc    = 1'b0;
        out_idx   = 2'd0;
        key_start = 1'b0;
        rk_idx    = 4'd0;
        done      = 1'b0;
        case (state_q)
            S_CTEXT_WRITE: begin
                we     = 1'b1;
                in_rc  = 1'b1;
                in_idx = count_q;
            end
            S_KEY_WRITE: begin
                in_rc     = 1'b1;
                in_idx    = count_q;
                key_start = (count_q == 2'd0);
            end
            S_INIT_ADDROUNDKEY, S_ADDROUNDKEY: begin
                sel     = SEL_ARK;
                we      = 1'b1;
                in_rc   = 1'b1;
                in_idx  = count_q;
                out_rc  = 1'b1;
                out_idx = count_q;
                rk_idx  = round_q;
            end
            S_INV_SHIFTROWS: begin
                sel     = SEL_ISR;
                we      = 1'b1;
                in_idx  = count_q;
                out_idx = count_q;
            end
            S_INV_SUBBYTES: begin
                sel     = SEL_ISB;
                we      = 1'b1;
                in_idx  = count_q;
                out_idx = count_q;
            end
            S_INV_MIXCOLUMNS: begin
                sel     = SEL_IMC;
                we      = 1'b1;
                in_rc   = 1'b1;
                in_idx  = count_q;
                out_rc  = 1'b1;
                out_idx = count_q;
            end
            S_DECRYPTION_DONE: begin
                done = 1'b1;
            end
            S_PTEXT_READ: begin
                out_rc  = 1'b1;
                out_idx = count_q;
            end
            default: begin
                sel = SEL_CTEXT;
            end
        endcase
    end

    assign bus.done                = done;
    assign bus.dbg_state           = state_q;
    assign bus.dbg_round           = round_q;
    assign bus.matrix_in_sel       = sel;
    assign bus.matrix_write_enable = we;
    assign bus.input_mat_row_col   = in_rc;
    assign bus.input_mat_idx       = in_idx;
    assign bus.output_mat_row_col  = out_rc;
    assign bus.output_mat_idx      = out_idx;
    assign bus.key_start           = key_start;
    assign bus.round_key_idx       = rk_idx;
    assign bus.count_4_out         = count_q;
endmodule

// File: tb/tb_aes_inv_state_manager.sv
// Scoreboard bench for aes_inv_state_manager: stimulus queues expected transactions, a monitor compares.
// With AES_INV_KEY_TIMEOUT_EN defined the DUT is built with a 16-cycle key watchdog and that path is exercised.
module tb_aes_inv_state_manager;
    typedef struct packed {
        logic [5:0] st;
        logic [3:0] rnd;
        logic [3:0] sel;
        logic       we;
        logic       irc;
        logic [1:0] iidx;
        logic       orc;
        logic [1:0] oidx;
        logic       ks;
        logic [3:0] rki;
        logic       dn;
        logic [7:0] lat;
        logic       kto;
    } rec_t;

`ifdef AES_INV_KEY_TIMEOUT_EN
    localparam int TB_KEY_TIMEOUT = 16;
`else
    localparam int TB_KEY_TIMEOUT = 256;
`endif

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    aes_inv_state_manager_if bus ();

    aes_inv_state_manager #(.KEY_TIMEOUT_CYCLES(TB_KEY_TIMEOUT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    rec_t exp_q[$];
    int   probe_seq = 0;
    int   tmo_cnt = 0;
    bit   stim_done = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic rec_t mk(input int st, input int rnd, input int sel, input int we,
                                input int irc, input int iidx, input int orc, input int oidx,
                                input int ks, input int rki, input int dn, input int lat, input int kto);
        rec_t r;
        r.st = 6'(st);   r.rnd = 4'(rnd);   r.sel = 4'(sel);   r.we = 1'(we);
        r.irc = 1'(irc); r.iidx = 2'(iidx); r.orc = 1'(orc);   r.oidx = 2'(oidx);
        r.ks = 1'(ks);   r.rki = 4'(rki);   r.dn = 1'(dn);     r.lat = 8'(lat);
        r.kto = 1'(kto);
        return r;
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf("st=%0d rnd=%0d sel=%0d we=%0d irc=%0d iidx=%0d orc=%0d oidx=%0d ks=%0d rki=%0d done=%0d lat=%0d kto=%0d",
                         r.st, r.rnd, r.sel, r.we, r.irc, r.iidx, r.orc, r.oidx, r.ks, r.rki, r.dn, r.lat, r.kto);
    endfunction

    task automatic probe();
        probe_seq++;
        @(posedge clock);
        #1;
    endtask

    task automatic push_idle();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic push_k(input rec_t e, input int stop, inout int k);
        if (k < stop) exp_q.push_back(e);
        k++;
    endtask

    // Ciphertext columns 0..3 with write enable, then the key_start cycle of KEY_WRITE.
    task automatic push_load();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 0, 0, 1, 1, i, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    endtask

    // Every cycle from the first INIT_ADDROUNDKEY cycle onward, truncated after `stop` cycles.
    task automatic push_rounds(input int stop);
        int k = 0;
        for (int i = 0; i < 4; i++) push_k(mk(4, 10, 4, 1, 1, i, 1, i, 0, 10, 0, 0, 0), stop, k);
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 4; i++) push_k(mk(5, r, 6, 1, 0, i, 0, i, 0, 0, 0, 0, 0), stop, k);
            for (int i = 0; i < 4; i++) push_k(mk(6, r, 5, 1, 0, i, 0, i, 0, 0, 0, 0, 0), stop, k);
            for (int i = 0; i < 4; i++) push_k(mk(7, r, 4, 1, 1, i, 1, i, 0, r, 0, 0, 0), stop, k);
            if (r > 0)
                for (int i = 0; i < 4; i++) push_k(mk(8, r, 7, 1, 1, i, 1, i, 0, 0, 0, 0, 0), stop, k);
        end
        push_k(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 160, 0), stop, k);
    endtask

    task automatic wait_st(input logic [5:0] s, input int lim);
        int n = 0;
        while (bus.dbg_state != s && n < lim) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (bus.dbg_state != s) tmo_cnt++;
    endtask

    task automatic start_load(input bit read_too);
        push_load();
        bus.start_write_n = 1'b0;
        bus.start_read_n  = read_too ? 1'b0 : 1'b1;
        @(posedge clock);
        #1;
        bus.start_write_n = 1'b1;
        bus.start_read_n  = 1'b1;
        wait_st(6'd3, 20);
    endtask

    // One decryption; a nonzero stop_at asserts reset that many cycles into the rounds.
    task automatic run(input bit read_too, input int stop_at);
        start_load(read_too);
        exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.start_read_n = 1'b0;
        probe();
        bus.start_read_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        bus.key_expand_done = 1'b1;
        push_rounds(stop_at > 0 ? stop_at : 1000);
        @(posedge clock);
        #1;
        bus.key_expand_done = 1'b0;
        if (stop_at > 0) begin
            repeat (stop_at) @(posedge clock);
            #1;
            reset_n = 1'b0;
            push_idle();
            probe();
            reset_n = 1'b1;
        end else begin
            repeat (20) @(posedge clock);
            #1;
            bus.start_write_n = 1'b0;
            @(posedge clock);
            #1;
            bus.start_write_n = 1'b1;
            wait_st(6'd9, 300);
            repeat (2) @(posedge clock);
            #1;
            exp_q.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            probe();
            for (int i = 0; i < 4; i++) exp_q.push_back(mk(10, 0, 0, 0, 0, 0, 1, i, 0, 0, 0, 0, 0));
            bus.start_read_n = 1'b0;
            @(posedge clock);
            #1;
            bus.start_read_n = 1'b1;
            repeat (5) @(posedge clock);
            #1;
            push_idle();
            probe();
        end
    endtask

    initial begin
        reset_n             = 1'b0;
        bus.start_write_n   = 1'b1;
        bus.start_read_n    = 1'b1;
        bus.key_expand_done = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        push_idle();
        probe();
        reset_n = 1'b1;
        push_idle();
        probe();
        bus.key_expand_done = 1'b1;
        @(posedge clock);
        #1;
        bus.key_expand_done = 1'b0;
        push_idle();
        probe();

        run(1'b1, 0);
        run(1'b0, 50);
        run(1'b0, 0);

`ifdef AES_INV_KEY_TIMEOUT_EN
        start_load(1'b0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        repeat (20) @(posedge clock);
        #1;
        push_idle();
        probe();
`endif

        repeat (2) @(posedge clock);
        #1;
        stim_done = 1'b1;
    end

    initial begin
        int   cyc = 0;
        int   t0 = 0;
        int   probe_seen = 0;
        logic done_prev = 1'b0;
        logic rise;
        rec_t act;
        rec_t e;
        while (!stim_done) begin
            @(negedge clock);
            if (stim_done) break;
            cyc++;
            if (bus.dbg_state == 6'd4 && bus.count_4_out == 2'd0 && bus.matrix_write_enable) t0 = cyc;
            rise      = bus.done && !done_prev;
            done_prev = bus.done;
            act.st   = bus.dbg_state;          act.rnd  = bus.dbg_round;
            act.sel  = bus.matrix_in_sel;      act.we   = bus.matrix_write_enable;
            act.irc  = bus.input_mat_row_col;  act.iidx = bus.input_mat_idx;
            act.orc  = bus.output_mat_row_col; act.oidx = bus.output_mat_idx;
            act.ks   = bus.key_start;          act.rki  = bus.round_key_idx;
            act.dn   = bus.done;
            act.lat  = rise ? 8'(cyc - t0) : 8'd0;
`ifdef AES_INV_KEY_TIMEOUT_EN
            act.kto  = bus.key_timeout;
`else
            act.kto  = 1'b0;
`endif
            if (act.we || act.ks || act.st == 6'd10 || rise || act.kto || probe_seq != probe_seen) begin
                probe_seen = probe_seq;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL txn%0d unexpected: got %s, wanted none", checks, fmt(act));
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL txn%0d: got %s | want %s", checks, fmt(act), fmt(e));
                    end else begin
                        $display("txn%0d ok: %s", checks, fmt(act));
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_txns: got %0d left over, want 0", exp_q.size());
        end
        checks++;
        if (tmo_cnt != 0) begin
            errors++;
            $display("FAIL state_wait_timeouts: got %0d, want 0", tmo_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
